// File: rtl/ram_burst_pkg.sv
// Shared definitions for the RAM burst master.
//   - Default widths for the 32x32 scratch RAM and the burst length field.
//   - Controller state encoding.
package ram_burst_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned LEN_W_DEF  = 6;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        FIN
    } state_t;

endpackage

// File: rtl/ram_rd_outreg.sv
// One-entry valid/ready output register for the read data stream.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   load_i        capture data_i and raise valid (wins over clear_i)
//   clear_i       drop valid, keep the last data word
//   data_i        word to capture
//   valid_o       registered valid
//   data_o        registered data, stable while valid_o is held
module ram_rd_outreg
    import ram_burst_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/ram_burst_master.sv
// Initiator-side burst controller for the single-port scratch RAM
// (synchronous write, asynchronous read). One command at a time.
// Ports:
//   CLK, RESET                        clock, synchronous active-high reset
//   CMD_VALID/READY/WR/ADDR/LEN       burst command handshake
//   WR_VALID/READY/DATA               write beat stream (into the RAM)
//   RD_VALID/READY/DATA               read beat stream (registered)
//   BUSY                              high while a burst is in progress
//   DONE                              one-cycle pulse at end of burst
//   RAM_ADDR/WE/DI, RAM_DO            RAM port (this block is its only driver)
module ram_burst_master
    import ram_burst_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WR,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [LEN_W-1:0]  CMD_LEN,
    input  logic              WR_VALID,
    output logic              WR_READY,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic              RD_VALID,
    input  logic              RD_READY,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_WE,
    output logic [DATA_W-1:0] RAM_DI,
    input  logic [DATA_W-1:0] RAM_DO
);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              cmd_ready_q;
    logic              wr_ready_q;
    logic              busy_q;
    logic              done_q;

    logic cmd_hs;
    logic wr_hs;
    logic rd_load;
    logic rd_clear;
    logic rd_valid;

    always_comb begin
        cmd_hs   = CMD_VALID & cmd_ready_q;
        wr_hs    = WR_VALID & wr_ready_q;
        // Output register refills whenever it is empty or being consumed,
        // so a consumer handshake and a new load share one edge.
        rd_load  = (state_q == READ) & (~rd_valid | RD_READY);
        rd_clear = (state_q == DRAIN) & RD_READY;
    end

    ram_rd_outreg #(
        .DATA_W (DATA_W)
    ) u_rd_outreg (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .load_i  (rd_load),
        .clear_i (rd_clear),
        .data_i  (RAM_DO),
        .valid_o (rd_valid),
        .data_o  (RD_DATA)
    );

    // Handshake flags are registered alongside the state transition so they
    // read 0 during reset and assert one cycle after the state is entered.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_hs) begin
                        addr_q <= CMD_ADDR;
                        cnt_q  <= CMD_LEN;
                        // Zero-length bursts pass through an empty DRAIN so
                        // DONE lands two cycles after the command handshake.
                        if (CMD_LEN == '0) begin
                            state_q <= DRAIN;
                        end else if (CMD_WR) begin
                            state_q    <= WRITE;
                            wr_ready_q <= 1'b1;
                        end else begin
                            state_q <= READ;
                        end
                    end else begin
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                WRITE: begin
                    if (wr_hs) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        cnt_q  <= cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            wr_ready_q <= 1'b1;
                        end
                    end else begin
                        wr_ready_q <= 1'b1;
                    end
                end
                READ: begin
                    if (rd_load) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        cnt_q  <= cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (~rd_valid | RD_READY) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end
                end
                FIN: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        CMD_READY = cmd_ready_q;
        WR_READY  = wr_ready_q;
        RD_VALID  = rd_valid;
        BUSY      = busy_q;
        DONE      = done_q;
        RAM_ADDR  = addr_q;
        RAM_WE    = wr_hs;
        RAM_DI    = wr_ready_q ? WR_DATA : '0;
    end

endmodule

// File: tb/tb_ram_burst_master.sv
module tb_ram_burst_master;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CMD_VALID, CMD_READY, CMD_WR;
    logic [4:0]  CMD_ADDR;
    logic [5:0]  CMD_LEN;
    logic        WR_VALID, WR_READY;
    logic [31:0] WR_DATA;
    logic        RD_VALID, RD_READY;
    logic [31:0] RD_DATA;
    logic        BUSY, DONE;
    logic [4:0]  RAM_ADDR;
    logic        RAM_WE;
    logic [31:0] RAM_DI, RAM_DO;

    int n_cmp = 0;
    int n_bad = 0;

    // Scratch RAM the DUT drives, and the reference image of its contents.
    logic [31:0] ram     [32];
    logic [31:0] ref_mem [32];

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (RAM_WE) ram[RAM_ADDR] <= RAM_DI;
    assign RAM_DO = ram[RAM_ADDR];

    ram_burst_master #(.DATA_W(32), .ADDR_W(5), .LEN_W(6)) dut (
        .CLK(CLK), .RESET(RESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WR(CMD_WR),
        .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
        .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_DATA(WR_DATA),
        .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA),
        .BUSY(BUSY), .DONE(DONE),
        .RAM_ADDR(RAM_ADDR), .RAM_WE(RAM_WE), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
    );

    typedef struct {
        bit         wr;
        logic [4:0] addr;
        logic [5:0] len;
        int         rmode;     // 0: RD_READY held, 1: toggling per valid cycle
        int         exp_we;
        int         exp_rd;
        int         exp_lat;   // cycles from command handshake to DONE
        int         exp_first; // cycles from handshake to first RD_VALID, -1 none
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, CMD_READY, 0);
        chk({tag, "_wr_ready"},  WR_READY,  0);
        chk({tag, "_rd_valid"},  RD_VALID,  0);
        chk({tag, "_rd_data"},   RD_DATA,   0);
        chk({tag, "_busy"},      BUSY,      0);
        chk({tag, "_done"},      DONE,      0);
        chk({tag, "_ram_we"},    RAM_WE,    0);
        chk({tag, "_ram_addr"},  RAM_ADDR,  0);
        chk({tag, "_ram_di"},    RAM_DI,    0);
    endtask

    task automatic wait_cmd_ready(input string tag);
        int wc;
        wc = 0;
        @(negedge CLK);
        #1;
        while (!CMD_READY && wc < 50) begin
            @(negedge CLK);
            #1;
            wc++;
        end
        chk({tag, "_cmd_ready_wait"}, CMD_READY, 1);
    endtask

    // rmode: 0 ready held, 1 toggling, 2 random. wmode: 0 WR_VALID held, 1 random.
    task automatic run_burst(input bit wr, input logic [4:0] a, input logic [5:0] len,
                             input int rmode, input int wmode,
                             output int done_lat, output int we_cnt,
                             output int rd_cnt, output int first_vld);
        logic [31:0] wq[$];
        logic [31:0] rq[$];
        int beat, cyc, viol, vcyc;
        bit prev_stall;
        logic [31:0] prev_data;
        done_lat = -1; we_cnt = 0; rd_cnt = 0; first_vld = -1;
        beat = 0; viol = 0; vcyc = 0; prev_stall = 0; prev_data = '0;
        for (int k = 0; k < int'(len); k++) begin
            if (wr) wq.push_back($urandom);
            else    rq.push_back(ref_mem[(int'(a) + k) % 32]);
        end
        wait_cmd_ready("burst");
        CMD_VALID = 1; CMD_WR = wr; CMD_ADDR = a; CMD_LEN = len;
        cyc = 0;
        while (cyc < 400) begin
            WR_VALID = wr && beat < int'(len) && (wmode == 0 || $urandom_range(0, 1) == 1);
            WR_DATA  = (wr && beat < int'(len)) ? wq[beat] : $urandom;
            RD_READY = (rmode == 0) ? 1'b1 : (rmode == 1) ? (vcyc % 2 == 0) : 1'($urandom_range(0, 1));
            #1;
            if (cyc > 0 && CMD_READY) viol++;
            if (RAM_WE) we_cnt++;
            if (prev_stall && (!RD_VALID || RD_DATA !== prev_data)) viol++;
            if (RD_VALID && first_vld < 0) first_vld = cyc;
            if (WR_VALID && WR_READY) begin
                ref_mem[(int'(a) + beat) % 32] = wq[beat];
                beat++;
            end
            if (RD_VALID && RD_READY) begin
                if (rq.size() > 0) chk("rd_data", RD_DATA, rq.pop_front());
                rd_cnt++;
            end
            prev_stall = RD_VALID && !RD_READY;
            prev_data  = RD_DATA;
            if (RD_VALID) vcyc++;
            if (DONE) begin
                done_lat = cyc;
                break;
            end
            @(negedge CLK);
            cyc++;
            if (cyc == 1) CMD_VALID = 0;
        end
        chk("done_seen", done_lat >= 0, 1);
        chk("handshake_rules", viol, 0);
        @(negedge CLK);
        WR_VALID = 0;
        #1;
        chk("done_one_cycle", DONE, 0);
        chk("idle_busy", BUSY, 0);
        chk("idle_cmd_ready", CMD_READY, 1);
    endtask

    initial begin
        vec_t vt[10];
        int lat, we, rd, fv, beat, idx, viol;
        bit got;
        logic [31:0] d[5];
        logic [31:0] d2[2];
        logic [31:0] rq6[3];
        bit w;
        logic [4:0] ra;
        logic [5:0] rl;

        vt[0] = '{1'b1, 5'd3,  6'd4,  0, 4,  0,  5,  -1};
        vt[1] = '{1'b0, 5'd3,  6'd4,  0, 0,  4,  6,   2};
        vt[2] = '{1'b1, 5'd30, 6'd4,  0, 4,  0,  5,  -1};
        vt[3] = '{1'b0, 5'd30, 6'd4,  1, 0,  4,  9,   2};
        vt[4] = '{1'b1, 5'd7,  6'd0,  0, 0,  0,  2,  -1};
        vt[5] = '{1'b0, 5'd9,  6'd0,  0, 0,  0,  2,  -1};
        vt[6] = '{1'b1, 5'd0,  6'd1,  0, 1,  0,  2,  -1};
        vt[7] = '{1'b0, 5'd0,  6'd1,  0, 0,  1,  3,   2};
        vt[8] = '{1'b1, 5'd10, 6'd40, 0, 40, 0,  41, -1};
        vt[9] = '{1'b0, 5'd10, 6'd33, 0, 0,  33, 35,  2};

        for (int i = 0; i < 32; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        RESET = 1; CMD_VALID = 0; CMD_WR = 0; CMD_ADDR = '0; CMD_LEN = '0;
        WR_VALID = 0; WR_DATA = '0; RD_READY = 0;
        repeat (3) @(negedge CLK);
        #1;
        chk_all_zero("reset");
        RESET = 0;

        // Directed table, including address wrap, zero and >32 lengths.
        for (int i = 0; i < 10; i++) begin
            run_burst(vt[i].wr, vt[i].addr, vt[i].len, vt[i].rmode, 0, lat, we, rd, fv);
            chk($sformatf("v%0d_we_cnt", i),    we,  vt[i].exp_we);
            chk($sformatf("v%0d_rd_cnt", i),    rd,  vt[i].exp_rd);
            chk($sformatf("v%0d_done_lat", i),  lat, vt[i].exp_lat);
            chk($sformatf("v%0d_first_vld", i), fv,  vt[i].exp_first);
        end

        // Reset after 2 of 5 write beats.
        wait_cmd_ready("t5");
        for (int k = 0; k < 5; k++) d[k] = $urandom;
        CMD_VALID = 1; CMD_WR = 1; CMD_ADDR = 5'd12; CMD_LEN = 6'd5;
        WR_VALID = 1; WR_DATA = d[0]; beat = 0; got = 0;
        for (int c = 0; c < 20 && beat < 2; c++) begin
            #1;
            if (DONE) got = 1;
            if (WR_VALID && WR_READY) begin
                ref_mem[12 + beat] = d[beat];
                beat++;
            end
            @(negedge CLK);
            CMD_VALID = 0;
            if (beat < 5) WR_DATA = d[beat];
        end
        chk("t5_beats_before_reset", beat, 2);
        WR_VALID = 0; RESET = 1;
        #1;
        if (DONE) got = 1;
        @(negedge CLK);
        #1;
        chk_all_zero("t5_reset");
        chk("t5_no_done", got, 0);
        RESET = 0;
        run_burst(1'b0, 5'd12, 6'd5, 0, 0, lat, we, rd, fv);
        chk("t5_readback_cnt", rd, 5);

        // CMD_VALID held through a burst; second command follows IDLE.
        wait_cmd_ready("t6");
        for (int k = 0; k < 3; k++) rq6[k] = ref_mem[20 + k];
        CMD_VALID = 1; CMD_WR = 0; CMD_ADDR = 5'd20; CMD_LEN = 6'd3;
        RD_READY = 1; WR_VALID = 0; idx = 0; viol = 0; got = 0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (c > 0 && CMD_READY) viol++;
            if (RD_VALID && RD_READY) begin
                if (idx < 3) chk("t6_rd_data", RD_DATA, rq6[idx]);
                idx++;
            end
            if (DONE) begin
                got = 1;
                break;
            end
            @(negedge CLK);
            if (c == 0) begin
                CMD_WR = 1; CMD_ADDR = 5'd25; CMD_LEN = 6'd2;
            end
        end
        chk("t6_first_done", got, 1);
        chk("t6_cmd_ready_low", viol, 0);
        chk("t6_rd_cnt", idx, 3);
        d2[0] = $urandom; d2[1] = $urandom;
        @(negedge CLK);
        WR_DATA = d2[0]; WR_VALID = 1;
        #1;
        chk("t6_cmd_ready_idle", CMD_READY, 1);
        chk("t6_busy_idle", BUSY, 0);
        @(negedge CLK);
        CMD_VALID = 0;
        #1;
        chk("t6_busy_second", BUSY, 1);
        chk("t6_wr_ready_second", WR_READY, 1);
        chk("t6_cmd_ready_second", CMD_READY, 0);
        beat = 0; got = 0;
        for (int c = 0; c < 20; c++) begin
            if (WR_VALID && WR_READY) begin
                ref_mem[25 + beat] = d2[beat];
                beat++;
            end
            if (DONE) begin
                got = 1;
                break;
            end
            @(negedge CLK);
            WR_VALID = (beat < 2);
            WR_DATA  = d2[(beat < 2) ? beat : 0];
            #1;
        end
        WR_VALID = 0;
        chk("t6_wr_beats", beat, 2);
        chk("t6_second_done", got, 1);

        // Randomized bursts against the reference image.
        for (int i = 0; i < 30; i++) begin
            w  = 1'($urandom_range(0, 1));
            ra = 5'($urandom);
            rl = 6'($urandom_range(0, 40));
            run_burst(w, ra, rl, 2, $urandom_range(0, 1), lat, we, rd, fv);
            chk($sformatf("r%0d_we_cnt", i), we, w ? int'(rl) : 0);
            chk($sformatf("r%0d_rd_cnt", i), rd, w ? 0 : int'(rl));
        end

        @(negedge CLK);
        for (int i = 0; i < 32; i++) chk($sformatf("mem_%0d", i), ram[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
